ddr5_timing_checker: RTL and testbench

DRAM-side responder for the memory scheduler's DDR5 command stream. It sits where the DIMM would be and tracks per-bank open/closed state plus elapsed-cycle ages for every command class. It flags any command that breaks bank state or DDR5 timing, drops that command, and optionally emits the read-data window a real device would drive.

---
 rtl/ddr5_timing_checker.sv | 243 ++++++++++++++++++++++++
 tb/tb_ddr5_timing_checker.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ddr5_timing_checker.sv
// ddr5_timing_checker
//   Stands in for a DDR5 DIMM on the scheduler's command bus. It tracks the
//   open/closed state of each bank and the age of each command class, flags
//   and drops any command that breaks bank state or DDR5 timing, and can
//   optionally produce the read-data window a real device would drive.
//
//   Optional feature macro: DDR5_CHK_RDDATA_EN (read-data window generator).
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   cmd_valid       command present this cycle
//   cmd_op          0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 PREA, 6 REF, 7 reserved
//   cmd_bg, cmd_ba  target bank group / bank
//   cmd_row         row address (ACT only)
//   viol            one-cycle pulse: last sampled command was illegal and dropped
//   viol_code       reason code while viol=1, else 0
//   viol_cnt        saturating violation count
//   rd_valid        read-data window active (0 when the feature is disabled)
module ddr5_timing_checker #(
    parameter int NBG   = 8,
    parameter int NBA   = 4,
    parameter int AGE_W = 10,
    parameter logic [AGE_W-1:0] T_RC        = 228,
    parameter logic [AGE_W-1:0] T_RAS       = 152,
    parameter logic [AGE_W-1:0] T_RRD_L     = 22,
    parameter logic [AGE_W-1:0] T_RRD_S     = 14,
    parameter logic [AGE_W-1:0] T_RP        = 74,
    parameter logic [AGE_W-1:0] T_RFC       = 710,
    parameter logic [AGE_W-1:0] T_CWD       = 76,
    parameter logic [AGE_W-1:0] T_CL        = 80,
    parameter logic [AGE_W-1:0] T_RCD       = 76,
    parameter logic [AGE_W-1:0] T_WR        = 60,
    parameter logic [AGE_W-1:0] T_RTP       = 36,
    parameter logic [AGE_W-1:0] T_CCD_L     = 22,
    parameter logic [AGE_W-1:0] T_CCD_S     = 14,
    parameter logic [AGE_W-1:0] T_CCD_L_WR  = 94,
    parameter logic [AGE_W-1:0] T_CCD_S_WR  = 14,
    parameter logic [AGE_W-1:0] T_BURST     = 16,
    parameter logic [AGE_W-1:0] T_CCD_L_RTW = 30,
    parameter logic [AGE_W-1:0] T_CCD_S_RTW = 30,
    parameter logic [AGE_W-1:0] T_CCD_L_WTR = 138,
    parameter logic [AGE_W-1:0] T_CCD_S_WTR = 102
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [2:0]  cmd_op,
    input  logic [2:0]  cmd_bg,
    input  logic [1:0]  cmd_ba,
    input  logic [15:0] cmd_row,
    output logic        viol,
    output logic [3:0]  viol_code,
    output logic [15:0] viol_cnt,
    output logic        rd_valid
);
    localparam int NB   = NBG * NBA;
    localparam int BI_W = $clog2(NB);

    typedef logic [AGE_W-1:0] age_t;
    typedef enum logic [2:0] {
        OP_NOP, OP_ACT, OP_RD, OP_WR, OP_PRE, OP_PREA, OP_REF, OP_RSV
    } op_e;

    localparam age_t AGE_MAX = '1;
    // Write recovery measured from the WR command: write latency + burst + tWR.
    localparam logic [AGE_W+1:0] T_WR_PRE = {2'b00, T_CWD} + {2'b00, T_BURST} + {2'b00, T_WR};

    op_e                       op;
    logic [BI_W-1:0]           tgt;
    logic [NB-1:0]             b_open;
    logic [NB-1:0][15:0]       b_row;
    logic [NB-1:0][AGE_W-1:0]  b_act_age, b_rd_age, b_wr_age, b_pre_age;
    logic [NBG-1:0][AGE_W-1:0] bg_act_age, bg_rd_age, bg_wr_age;
    age_t                      ref_age;
    logic [3:0]                code;
    logic                      legal;

    assign op  = op_e'(cmd_op);
    assign tgt = BI_W'({cmd_bg, cmd_ba});

    // The open row is kept as device state for debug visibility; no check uses it.
    logic unused_row;
    assign unused_row = ^b_row;

    function automatic age_t sat_inc(input age_t a);
        return (a == AGE_MAX) ? a : a + 1'b1;
    endfunction

    // Precharge checks for one bank; a closed bank always precharges legally.
    function automatic logic [3:0] pre_chk(input logic open, input age_t a,
                                           input age_t r, input age_t w);
        if (!open)                 return 4'd0;
        if (a < T_RAS)             return 4'd11;
        if (r < T_RTP)             return 4'd12;
        if ({2'b00, w} < T_WR_PRE) return 4'd13;
        return 4'd0;
    endfunction

    logic       same, rrd_hit, ccd_hit, rtw_hit, wtr_hit;
    logic [3:0] pc, prea_code;

    always_comb begin
        same      = 1'b0;
        rrd_hit   = 1'b0;
        ccd_hit   = 1'b0;
        rtw_hit   = 1'b0;
        wtr_hit   = 1'b0;
        pc        = 4'd0;
        prea_code = 4'd0;
        code      = 4'd0;
        // Inter-bank spacing: the target group uses the _L value, others _S.
        for (int g = 0; g < NBG; g++) begin
            same = (g == int'(cmd_bg));
            if (bg_act_age[g] < (same ? T_RRD_L : T_RRD_S)) rrd_hit = 1'b1;
            if (op == OP_RD && bg_rd_age[g] < (same ? T_CCD_L : T_CCD_S)) ccd_hit = 1'b1;
            if (op == OP_WR && bg_wr_age[g] < (same ? T_CCD_L_WR : T_CCD_S_WR)) ccd_hit = 1'b1;
            if (bg_rd_age[g] < (same ? T_CCD_L_RTW : T_CCD_S_RTW)) rtw_hit = 1'b1;
            if (bg_wr_age[g] < (same ? T_CCD_L_WTR : T_CCD_S_WTR)) wtr_hit = 1'b1;
        end
        // PREA reports the lowest code found across all open banks.
        for (int b = 0; b < NB; b++) begin
            pc = pre_chk(b_open[b], b_act_age[b], b_rd_age[b], b_wr_age[b]);
            if (pc != 4'd0 && (prea_code == 4'd0 || pc < prea_code)) prea_code = pc;
        end
        if (cmd_valid && op != OP_NOP) begin
            if (ref_age < T_RFC) code = 4'd1;
            else begin
                case (op)
                    OP_ACT: begin
                        if (b_open[tgt])                   code = 4'd2;
                        else if (b_act_age[tgt] < T_RC)    code = 4'd3;
                        else if (b_pre_age[tgt] < T_RP)    code = 4'd4;
                        else if (rrd_hit)                  code = 4'd5;
                    end
                    OP_RD, OP_WR: begin
                        if (!b_open[tgt])                  code = 4'd6;
                        else if (b_act_age[tgt] < T_RCD)   code = 4'd7;
                        else if (ccd_hit)                  code = 4'd8;
                        else if (op == OP_WR && rtw_hit)   code = 4'd9;
                        else if (op == OP_RD && wtr_hit)   code = 4'd10;
                    end
                    OP_PRE:  code = pre_chk(b_open[tgt], b_act_age[tgt], b_rd_age[tgt], b_wr_age[tgt]);
                    OP_PREA: code = prea_code;
                    OP_REF:  if (|b_open) code = 4'd14;
                    default: code = 4'd15;
                endcase
            end
        end
    end

    assign legal = cmd_valid && op != OP_NOP && code == 4'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_open     <= '0;
            b_row      <= '0;
            b_act_age  <= '1;
            b_rd_age   <= '1;
            b_wr_age   <= '1;
            b_pre_age  <= '1;
            bg_act_age <= '1;
            bg_rd_age  <= '1;
            bg_wr_age  <= '1;
            ref_age    <= '1;
            viol       <= 1'b0;
            viol_code  <= 4'd0;
            viol_cnt   <= 16'd0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                b_act_age[b] <= sat_inc(b_act_age[b]);
                b_rd_age[b]  <= sat_inc(b_rd_age[b]);
                b_wr_age[b]  <= sat_inc(b_wr_age[b]);
                b_pre_age[b] <= sat_inc(b_pre_age[b]);
            end
            for (int g = 0; g < NBG; g++) begin
                bg_act_age[g] <= sat_inc(bg_act_age[g]);
                bg_rd_age[g]  <= sat_inc(bg_rd_age[g]);
                bg_wr_age[g]  <= sat_inc(bg_wr_age[g]);
            end
            ref_age <= sat_inc(ref_age);
            // Event ages restart at 1 on the sampling edge (later writes win).
            if (legal) begin
                case (op)
                    OP_ACT: begin
                        b_open[tgt]        <= 1'b1;
                        b_row[tgt]         <= cmd_row;
                        b_act_age[tgt]     <= age_t'(1);
                        bg_act_age[cmd_bg] <= age_t'(1);
                    end
                    OP_RD: begin
                        b_rd_age[tgt]     <= age_t'(1);
                        bg_rd_age[cmd_bg] <= age_t'(1);
                    end
                    OP_WR: begin
                        b_wr_age[tgt]     <= age_t'(1);
                        bg_wr_age[cmd_bg] <= age_t'(1);
                    end
                    OP_PRE: begin
                        b_open[tgt]    <= 1'b0;
                        b_pre_age[tgt] <= age_t'(1);
                    end
                    OP_PREA: begin
                        b_open <= '0;
                        for (int b = 0; b < NB; b++) b_pre_age[b] <= age_t'(1);
                    end
                    OP_REF:  ref_age <= age_t'(1);
                    default: ;
                endcase
            end
            viol      <= (code != 4'd0);
            viol_code <= code;
            if (code != 4'd0 && viol_cnt != 16'hFFFF) viol_cnt <= viol_cnt + 16'd1;
        end
    end

`ifdef DDR5_CHK_RDDATA_EN
    localparam int CL = int'(T_CL);

    // Stage k of vld_pipe holds a RD sampled k edges ago; the last stage
    // (re)loads the burst counter so overlapping bursts merge.
    logic          rd_fire;
    logic [CL:1]   vld_pipe;
    age_t          burst_cnt;

    assign rd_fire = legal && op == OP_RD;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe  <= '0;
            burst_cnt <= '0;
        end else begin
            vld_pipe <= {vld_pipe[CL-1:1], rd_fire};
            if (vld_pipe[CL])            burst_cnt <= T_BURST;
            else if (burst_cnt != '0)    burst_cnt <= burst_cnt - 1'b1;
        end
    end

    assign rd_valid = (burst_cnt != '0);
`else
    assign rd_valid = 1'b0;
`endif

endmodule

// File: tb/tb_ddr5_timing_checker.sv
// Scoreboard bench for ddr5_timing_checker: the driver pushes the expected
// verdict of each command; a negedge monitor pops and compares when due.
module tb_ddr5_timing_checker;
    localparam logic [2:0] OP_NOP = 3'd0, OP_ACT = 3'd1, OP_RD = 3'd2, OP_WR = 3'd3,
                           OP_PRE = 3'd4, OP_PREA = 3'd5, OP_REF = 3'd6, OP_RSV = 3'd7;
    localparam int T_CL = 80, T_BURST = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [2:0]  cmd_op = 3'd0, cmd_bg = 3'd0;
    logic [1:0]  cmd_ba = 2'd0;
    logic [15:0] cmd_row = 16'd0;
    logic        viol, rd_valid;
    logic [3:0]  viol_code;
    logic [15:0] viol_cnt;

    ddr5_timing_checker dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_bg(cmd_bg), .cmd_ba(cmd_ba), .cmd_row(cmd_row),
        .viol(viol), .viol_code(viol_code), .viol_cnt(viol_cnt), .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [3:0]  code;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int   rd_s[$];
    int   n_vec = 0, n_err = 0, exp_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare the verdict that falls due this cycle, otherwise expect quiet.
    always @(negedge clk) begin
        exp_t e;
        logic exp_rv;
        if (!rst) begin
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                chk("viol", 32'(viol), 32'(e.code != 4'd0));
                chk("viol_code", 32'(viol_code), 32'(e.code));
                chk("viol_cnt", 32'(viol_cnt), 32'(e.cnt));
            end else begin
                chk("viol_idle", 32'(viol), 32'd0);
                chk("viol_code_idle", 32'(viol_code), 32'd0);
            end
            exp_rv = 1'b0;
`ifdef DDR5_CHK_RDDATA_EN
            foreach (rd_s[i])
                if (cyc >= rd_s[i] + T_CL && cyc <= rd_s[i] + T_CL + T_BURST - 1) exp_rv = 1'b1;
`endif
            chk("rd_valid", 32'(rd_valid), 32'(exp_rv));
        end
    end

    // One cycle of stimulus; code is the expected verdict (0 = legal).
    task automatic step(input logic v, input logic [2:0] op, input logic [2:0] bg,
                        input logic [1:0] ba, input int code);
        @(posedge clk); #1;
        cmd_valid = v; cmd_op = op; cmd_bg = bg; cmd_ba = ba; cmd_row = 16'($urandom);
        if (v && op != OP_NOP) begin
            if (code != 0 && exp_cnt < 65535) exp_cnt++;
            q.push_back('{due: cyc + 1, code: 4'(code), cnt: 16'(exp_cnt)});
            if (code == 0 && op == OP_RD) rd_s.push_back(cyc + 1);
        end
    endtask

    task automatic cmd(input logic [2:0] op, input logic [2:0] bg, input logic [1:0] ba, input int code);
        step(1'b1, op, bg, ba, code);
    endtask

    // Idle cycles carry an ACT with valid low: it must be ignored entirely.
    task automatic idle(input int n);
        repeat (n) step(1'b0, OP_ACT, 3'd0, 2'd0, 0);
    endtask

    // Next command lands d cycles after the previous one.
    task automatic gap(input int d);
        idle(d - 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rst = 1'b1;
        q.delete(); rd_s.delete(); exp_cnt = 0;
        #1;
        chk("rst_viol", 32'(viol), 32'd0);
        chk("rst_viol_code", 32'(viol_code), 32'd0);
        chk("rst_viol_cnt", 32'(viol_cnt), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        // tRCD boundary, legal read (and its data window)
        do_reset();
        cmd(OP_ACT, 0, 0, 0);
        gap(76);  cmd(OP_RD, 0, 0, 0);
        idle(100);

        // tRCD miss is dropped: bank stays open, RD leaves no tCCD trace
        do_reset();
        cmd(OP_ACT, 0, 0, 0);
        gap(75);  cmd(OP_RD, 0, 0, 7);
        gap(1);   cmd(OP_RD, 0, 0, 0);
        gap(1);   cmd(OP_ACT, 0, 0, 2);
        idle(100);

        // tRRD_L / tRRD_S
        do_reset();
        cmd(OP_ACT, 0, 0, 0);
        gap(14);  cmd(OP_ACT, 1, 0, 0);
        gap(7);   cmd(OP_ACT, 0, 1, 5);
        gap(1);   cmd(OP_ACT, 0, 1, 5);
        gap(6);   cmd(OP_ACT, 0, 1, 0);
        idle(2);

        // WTR / RTW / CCD across groups
        do_reset();
        cmd(OP_ACT, 2, 0, 0);
        gap(22);  cmd(OP_ACT, 2, 1, 0);
        gap(22);  cmd(OP_ACT, 3, 0, 0);
        gap(32);  cmd(OP_WR, 2, 0, 0);
        gap(101); cmd(OP_RD, 3, 0, 10);
        gap(1);   cmd(OP_RD, 3, 0, 0);
        gap(29);  cmd(OP_WR, 3, 0, 9);
        gap(6);   cmd(OP_RD, 2, 1, 10);
        gap(1);   cmd(OP_RD, 2, 1, 0);
        gap(1);   cmd(OP_RD, 2, 0, 8);
        idle(100);

        // tRFC, reserved opcode, REF with an open bank
        do_reset();
        cmd(OP_REF, 0, 0, 0);
        gap(5);   cmd(OP_NOP, 0, 0, 0);
        gap(704); cmd(OP_ACT, 0, 0, 1);
        gap(1);   cmd(OP_ACT, 0, 0, 0);
        gap(1);   cmd(OP_RSV, 0, 0, 15);
        gap(1);   cmd(OP_REF, 0, 0, 14);
        idle(2);

        // tRAS, PRE to closed bank, tRC, tRP
        do_reset();
        cmd(OP_ACT, 0, 0, 0);
        gap(151); cmd(OP_PRE, 0, 0, 11);
        gap(1);   cmd(OP_PRE, 0, 0, 0);
        gap(18);  cmd(OP_PRE, 0, 0, 0);
        gap(56);  cmd(OP_ACT, 0, 0, 3);
        gap(2);   cmd(OP_ACT, 0, 0, 4);
        gap(16);  cmd(OP_ACT, 0, 0, 0);
        idle(2);

        // Write recovery, PREA, closed-bank RD, tRTP via PREA
        do_reset();
        cmd(OP_ACT, 1, 2, 0);
        gap(76);  cmd(OP_WR, 1, 2, 0);
        gap(151); cmd(OP_PRE, 1, 2, 13);
        gap(1);   cmd(OP_PREA, 0, 0, 0);
        gap(1);   cmd(OP_RD, 1, 2, 6);
        gap(73);  cmd(OP_ACT, 1, 2, 0);
        gap(117); cmd(OP_RD, 1, 2, 0);
        gap(35);  cmd(OP_PREA, 0, 0, 12);
        gap(1);   cmd(OP_PRE, 1, 2, 0);
        idle(100);

        // Reset in the middle of a read burst
        do_reset();
        cmd(OP_ACT, 0, 0, 0);
        gap(75);  cmd(OP_RD, 0, 0, 7);
        gap(1);   cmd(OP_RD, 0, 0, 0);
        idle(90);
        do_reset();
        idle(5);

        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
